cbb_rs_downsizer: RTL and testbench

- Stream width downsizer placed directly downstream of the backward register slice.
- Accepts one wide word per slave handshake and emits it as P_RATIO narrow beats on the master side, least-significant slice first.
- Supports partial words (fewer valid slices) and carries a packet-last flag to the final emitted beat.
- Both sides are valid/ready; the output is fully registered so it can drive long routes into narrow consumers.

---
 rtl/cbb_rs_downsizer_pkg.sv | 29 ++
 rtl/cbb_rs_downsizer.sv | 127 ++++++++++++
 tb/tb_cbb_rs_downsizer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cbb_rs_downsizer_pkg.sv
// rtl/cbb_rs_downsizer_pkg.sv - shared state encoding and elaboration helpers for the downsizer
package cbb_rs_downsizer_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_SEND  = 1'b1
  } state_t;

  function automatic int cbb_clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Slice counter width; a ratio of 1 would otherwise collapse to zero bits.
  function automatic int cbb_cnt_width(input int ratio);
    return (cbb_clog2(ratio) < 1) ? 1 : cbb_clog2(ratio);
  endfunction

  function automatic bit cbb_params_ok(input int data_width, input int ratio);
    return (ratio >= 2) && ((data_width % ratio) == 0);
  endfunction

endpackage

// File: rtl/cbb_rs_downsizer.sv
// rtl/cbb_rs_downsizer.sv - wide-to-narrow stream downsizer with registered master side
module cbb_rs_downsizer
  import cbb_rs_downsizer_pkg::*;
#(
  parameter  int P_DATA_WIDTH = 64,
  parameter  int P_RATIO      = 4,
  localparam int P_OUT_WIDTH  = P_DATA_WIDTH / P_RATIO,
  localparam int P_CNT_WIDTH  = cbb_cnt_width(P_RATIO)
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    slv_i_valid,
  input  logic [P_DATA_WIDTH-1:0] slv_i_data,
  input  logic [P_CNT_WIDTH-1:0]  slv_i_nslc,
  input  logic                    slv_i_last,
  output logic                    slv_o_ready,
  output logic                    mst_o_valid,
  output logic [P_OUT_WIDTH-1:0]  mst_o_data,
  output logic                    mst_o_last,
  input  logic                    mst_i_ready
);

  if (!cbb_params_ok(P_DATA_WIDTH, P_RATIO)) begin : g_param_check
    $error("cbb_rs_downsizer: P_RATIO must be >= 2 and divide P_DATA_WIDTH");
  end

  state_t                   state_q, state_d;
  logic [P_CNT_WIDTH-1:0]   idx_q, idx_d;
  logic [P_CNT_WIDTH-1:0]   nslc_q, nslc_d;
  logic [P_CNT_WIDTH-1:0]   idx_inc;
  logic                     last_q, last_d;
  logic                     valid_q, valid_d;
  logic [P_OUT_WIDTH-1:0]   out_q, out_d;
  logic                     olast_q, olast_d;
  logic [P_DATA_WIDTH-1:0]  word_q;
  logic [P_OUT_WIDTH-1:0]   slc [P_RATIO];
  logic                     beat_fire;
  logic                     beat_final;
  logic                     word_load;

  for (genvar k = 0; k < P_RATIO; k++) begin : g_slice
    assign slc[k] = word_q[k*P_OUT_WIDTH +: P_OUT_WIDTH];
  end

  assign beat_fire   = valid_q & mst_i_ready;
  assign beat_final  = (idx_q == nslc_q);
  // Ready never looks at slv_i_valid, so no combinational loop through upstream.
  assign slv_o_ready = (state_q == ST_EMPTY) | (beat_fire & beat_final);
  assign word_load   = slv_i_valid & slv_o_ready;
  assign idx_inc     = idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    nslc_d  = nslc_q;
    last_d  = last_q;
    valid_d = valid_q;
    out_d   = out_q;
    olast_d = olast_q;

    case (state_q)
      ST_EMPTY: begin
        state_d = ST_EMPTY;
      end
      ST_SEND: begin
        if (beat_fire) begin
          if (!beat_final) begin
            idx_d   = idx_inc;
            out_d   = slc[idx_inc];
            olast_d = last_q & (idx_inc == nslc_q);
          end else begin
            state_d = ST_EMPTY;
            valid_d = 1'b0;
            olast_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_EMPTY;
        valid_d = 1'b0;
        olast_d = 1'b0;
      end
    endcase

    // A load overrides the drain so the final beat hands over with no bubble.
    if (word_load) begin
      state_d = ST_SEND;
      valid_d = 1'b1;
      idx_d   = '0;
      nslc_d  = slv_i_nslc;
      last_d  = slv_i_last;
      out_d   = slv_i_data[P_OUT_WIDTH-1:0];
      olast_d = slv_i_last & (slv_i_nslc == '0);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_EMPTY;
      idx_q   <= '0;
      nslc_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      out_q   <= '0;
      olast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      nslc_q  <= nslc_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      olast_q <= olast_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (word_load) begin
      word_q <= slv_i_data;
    end
  end

  assign mst_o_valid = valid_q;
  assign mst_o_data  = out_q;
  assign mst_o_last  = olast_q;

endmodule

// File: tb/tb_cbb_rs_downsizer.sv
// tb/tb_cbb_rs_downsizer.sv - self-checking bench for cbb_rs_downsizer
module tb_cbb_rs_downsizer;

  localparam int DW = 64;
  localparam int R  = 4;
  localparam int OW = 16;
  localparam int CW = 2;

  typedef struct {
    logic [OW-1:0] d;
    logic          l;
    logic          fin;
  } beat_t;

  logic          i_clk = 1'b0;
  logic          i_rstn;
  logic          slv_i_valid;
  logic [DW-1:0] slv_i_data;
  logic [CW-1:0] slv_i_nslc;
  logic          slv_i_last;
  logic          slv_o_ready;
  logic          mst_o_valid;
  logic [OW-1:0] mst_o_data;
  logic          mst_o_last;
  logic          mst_i_ready;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  beat_t         exp_q[$];
  logic [OW-1:0] log_d[$];
  logic          log_l[$];
  int            log_c[$];

  cbb_rs_downsizer #(.P_DATA_WIDTH(DW), .P_RATIO(R)) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .slv_i_valid (slv_i_valid),
    .slv_i_data  (slv_i_data),
    .slv_i_nslc  (slv_i_nslc),
    .slv_i_last  (slv_i_last),
    .slv_o_ready (slv_o_ready),
    .mst_o_valid (mst_o_valid),
    .mst_o_data  (mst_o_data),
    .mst_o_last  (mst_o_last),
    .mst_i_ready (mst_i_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic note_timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timeout (t=%0t)", name, $time);
  endtask

  // Reference model: a queue of beats still owed by the DUT, updated at each
  // mid-cycle sample from the handshakes that will occur on the next edge.
  always @(negedge i_clk) begin
    beat_t b;
    logic  exp_ready;
    cyc++;
    if (!i_rstn) begin
      exp_q.delete();
      chk("rst_valid", 64'(mst_o_valid), 64'd0);
      chk("rst_data", 64'(mst_o_data), 64'd0);
      chk("rst_last", 64'(mst_o_last), 64'd0);
      chk("rst_ready", 64'(slv_o_ready), 64'd1);
    end else begin
      exp_ready = (exp_q.size() == 0) || (mst_i_ready && exp_q[0].fin);
      chk("mdl_valid", 64'(mst_o_valid), 64'(exp_q.size() != 0));
      chk("mdl_ready", 64'(slv_o_ready), 64'(exp_ready));
      if (mst_o_valid && exp_q.size() != 0) begin
        chk("mdl_data", 64'(mst_o_data), 64'(exp_q[0].d));
        chk("mdl_last", 64'(mst_o_last), 64'(exp_q[0].l));
      end
      if (mst_o_valid && mst_i_ready) begin
        log_d.push_back(mst_o_data);
        log_l.push_back(mst_o_last);
        log_c.push_back(cyc);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (slv_i_valid && slv_o_ready) begin
        for (int k = 0; k <= int'(slv_i_nslc); k++) begin
          b.d   = slv_i_data[k*OW +: OW];
          b.fin = (k == int'(slv_i_nslc));
          b.l   = slv_i_last && b.fin;
          exp_q.push_back(b);
        end
      end
    end
  end

  task automatic clear_log();
    log_d.delete();
    log_l.delete();
    log_c.delete();
  endtask

  // Presents a word until it is accepted; returns with inputs settled just after that edge.
  task automatic send_word(input logic [DW-1:0] d, input logic [CW-1:0] n, input logic l,
                           input bit hold, output int waits);
    bit done;
    slv_i_valid = 1'b1;
    slv_i_data  = d;
    slv_i_nslc  = n;
    slv_i_last  = l;
    waits = 0;
    done  = 1'b0;
    while (!done) begin
      @(negedge i_clk);
      if (slv_o_ready) begin
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 100) begin
          note_timeout("send_word");
          done = 1'b1;
        end
      end
    end
    @(posedge i_clk);
    #1;
    if (!hold) slv_i_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge i_clk);
    while (mst_o_valid && guard < 100) begin
      @(negedge i_clk);
      guard++;
    end
    if (guard >= 100) note_timeout("wait_idle");
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    logic [OW-1:0] e4[4];
    int w;
    i_rstn      = 1'b0;
    slv_i_valid = 1'b0;
    slv_i_data  = '0;
    slv_i_nslc  = '0;
    slv_i_last  = 1'b0;
    mst_i_ready = 1'b1;

    // Reset release
    repeat (3) @(posedge i_clk);
    #1 i_rstn = 1'b1;
    #1;
    chk("rel_ready", 64'(slv_o_ready), 64'd1);
    chk("rel_valid", 64'(mst_o_valid), 64'd0);
    chk("rel_data", 64'(mst_o_data), 64'd0);
    @(posedge i_clk);
    #1;

    // Single full word, ready always high
    e4[0] = 16'h1111; e4[1] = 16'h2222; e4[2] = 16'h3333; e4[3] = 16'h4444;
    send_word(64'h4444_3333_2222_1111, 2'd3, 1'b1, 1'b0, w);
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      chk("t2_valid", 64'(mst_o_valid), 64'd1);
      chk("t2_data", 64'(mst_o_data), 64'(e4[k]));
      chk("t2_last", 64'(mst_o_last), 64'(k == 3));
    end
    @(negedge i_clk);
    chk("t2_idle_valid", 64'(mst_o_valid), 64'd0);
    chk("t2_idle_ready", 64'(slv_o_ready), 64'd1);
    @(posedge i_clk);
    #1;

    // Back-to-back full words
    clear_log();
    send_word(64'hA004_A003_A002_A001, 2'd3, 1'b0, 1'b1, w);
    send_word(64'hB004_B003_B002_B001, 2'd3, 1'b1, 1'b0, w);
    chk("t3_b_wait", 64'(w), 64'd3);
    wait_idle();
    chk("t3_beats", 64'(log_d.size()), 64'd8);
    if (log_d.size() == 8) begin
      chk("t3_nobubble", 64'(log_c[7] - log_c[0]), 64'd7);
      chk("t3_a3", 64'(log_d[3]), 64'hA004);
      chk("t3_b0", 64'(log_d[4]), 64'hB001);
      chk("t3_lastA", 64'(log_l[3]), 64'd0);
      chk("t3_lastB", 64'(log_l[7]), 64'd1);
    end

    // Partial word, two slices
    clear_log();
    send_word(64'hDEAD_BEEF_BBBB_AAAA, 2'd1, 1'b1, 1'b0, w);
    wait_idle();
    chk("t4_beats", 64'(log_d.size()), 64'd2);
    if (log_d.size() == 2) begin
      chk("t4_d0", 64'(log_d[0]), 64'hAAAA);
      chk("t4_d1", 64'(log_d[1]), 64'hBBBB);
      chk("t4_l0", 64'(log_l[0]), 64'd0);
      chk("t4_l1", 64'(log_l[1]), 64'd1);
    end
    chk("t4_ready", 64'(slv_o_ready), 64'd1);

    // Single-slice words stream one per cycle
    clear_log();
    send_word(64'h0000_0000_0000_0C01, 2'd0, 1'b0, 1'b1, w);
    send_word(64'h0000_0000_0000_0C02, 2'd0, 1'b1, 1'b1, w);
    chk("t5_w2_wait", 64'(w), 64'd0);
    send_word(64'h0000_0000_0000_0C03, 2'd0, 1'b0, 1'b0, w);
    chk("t5_w3_wait", 64'(w), 64'd0);
    wait_idle();
    chk("t5_beats", 64'(log_d.size()), 64'd3);
    if (log_d.size() == 3) begin
      chk("t5_rate", 64'(log_c[2] - log_c[0]), 64'd2);
      chk("t5_d2", 64'(log_d[2]), 64'h0C03);
      chk("t5_l1", 64'(log_l[1]), 64'd1);
      chk("t5_l2", 64'(log_l[2]), 64'd0);
    end

    // Stall on beat 2
    clear_log();
    send_word(64'h4444_3333_2222_1111, 2'd3, 1'b1, 1'b0, w);
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    mst_i_ready = 1'b0;
    repeat (5) begin
      @(negedge i_clk);
      chk("t6_stall_data", 64'(mst_o_data), 64'h3333);
      chk("t6_stall_valid", 64'(mst_o_valid), 64'd1);
      chk("t6_stall_ready", 64'(slv_o_ready), 64'd0);
    end
    @(posedge i_clk);
    #1 mst_i_ready = 1'b1;
    wait_idle();
    chk("t6_beats", 64'(log_d.size()), 64'd4);
    if (log_d.size() == 4) begin
      chk("t6_d2", 64'(log_d[2]), 64'h3333);
      chk("t6_d3", 64'(log_d[3]), 64'h4444);
      chk("t6_l3", 64'(log_l[3]), 64'd1);
    end

    // Reset in the middle of a word
    send_word(64'h8888_7777_6666_5555, 2'd3, 1'b1, 1'b0, w);
    @(posedge i_clk); #1;
    i_rstn = 1'b0;
    #1;
    clear_log();
    chk("t7_valid", 64'(mst_o_valid), 64'd0);
    chk("t7_data", 64'(mst_o_data), 64'd0);
    chk("t7_last", 64'(mst_o_last), 64'd0);
    chk("t7_ready", 64'(slv_o_ready), 64'd1);
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rstn = 1'b1;
    @(posedge i_clk); #1;
    send_word(64'hDDDD_CCCC_BBBB_AAAA, 2'd3, 1'b0, 1'b0, w);
    wait_idle();
    chk("t7_beats", 64'(log_d.size()), 64'd4);
    if (log_d.size() == 4) begin
      chk("t7_d0", 64'(log_d[0]), 64'hAAAA);
      chk("t7_d3", 64'(log_d[3]), 64'hDDDD);
      chk("t7_l3", 64'(log_l[3]), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

endmodule
